// File: rtl/alu_pkg.sv
// Shared types and op-class helpers for the iterative ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SLT = 4'b0100,
        OP_XOR = 4'b0101,
        OP_SUB = 4'b0110,
        OP_BEQ = 4'b1000,
        OP_BNE = 4'b1001,
        OP_BLT = 4'b1010,
        OP_BGE = 4'b1011,
        OP_SLL = 4'b1101,
        OP_SRL = 4'b1110,
        OP_SRA = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == 4'b1101) || (op[3:1] == 3'b111);
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Shifter for SLL/SRL/SRA: 1 bit per cycle, or a single-cycle barrel shifter
// when ALU_BARREL_SHIFT_EN is defined. kind_i: 01=SLL, 10=SRL, 11=SRA.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [1:0]            kind_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [SHAMT_W-1:0]    shamt_i,
    output logic                  last_o,
    output logic [DATA_WIDTH-1:0] result_o
);

`ifdef ALU_BARREL_SHIFT_EN
    always_comb begin
        case (kind_i)
            2'b01:   result_o = a_i << shamt_i;
            2'b10:   result_o = a_i >> shamt_i;
            default: result_o = $unsigned($signed(a_i) >>> shamt_i);
        endcase
    end
    assign last_o = 1'b0;
`else
    logic [DATA_WIDTH-1:0] work_q, work_d, step;
    logic [SHAMT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]            kind_q, kind_d;

    always_comb begin
        case (kind_q)
            2'b01:   step = work_q << 1;
            2'b10:   step = work_q >> 1;
            default: step = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
        endcase
    end

    // The counter free-runs down to zero; the FSM only looks at it while in SHIFT.
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        kind_d = kind_q;
        if (load_i) begin
            work_d = a_i;
            cnt_d  = shamt_i;
            kind_d = kind_i;
        end else if (cnt_q != '0) begin
            work_d = step;
            cnt_d  = cnt_q - SHAMT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            cnt_q  <= '0;
            kind_q <= 2'b00;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
        end
    end

    assign last_o   = (cnt_q == SHAMT_W'(1));
    assign result_o = step;
`endif

endmodule

// File: rtl/iterative_alu.sv
// Execute-stage ALU with valid/ready handshakes; shifts iterate unless
// ALU_BARREL_SHIFT_EN is defined. Holds the FSM and result registers.
module iterative_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  BranchTaken,
    output logic                  Illegal,
    output alu_state_e            dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // producers hold their request until ready, and DONE holds the result
    // stable until out_ready.
    alu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  br_q, br_d, ill_q, ill_d;

    logic                  accept, load_shift, shift_last;
    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] shift_res, alu_res;
    logic                  cond, ill;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign shamt    = SrcB[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        cond    = 1'b0;
        ill     = 1'b0;
        case (Operation)
            OP_AND: alu_res = SrcA & SrcB;
            OP_OR:  alu_res = SrcA | SrcB;
            OP_ADD: alu_res = SrcA + SrcB;
            OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            OP_XOR: alu_res = SrcA ^ SrcB;
            OP_SUB: alu_res = SrcA - SrcB;
            OP_BEQ: cond = (SrcA == SrcB);
            OP_BNE: cond = (SrcA != SrcB);
            OP_BLT: cond = ($signed(SrcA) < $signed(SrcB));
            OP_BGE: cond = ($signed(SrcA) >= $signed(SrcB));
            OP_SLL, OP_SRL, OP_SRA: ;
            default: ill = 1'b1;
        endcase
        if (is_branch(Operation)) alu_res = {{(DATA_WIDTH-1){1'b0}}, cond};
    end

    alu_shift_unit #(.DATA_WIDTH(DATA_WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
        .clk      (clk),
        .rst_n    (reset),
        .load_i   (load_shift),
        .kind_i   (Operation[1:0]),
        .a_i      (SrcA),
        .shamt_i  (shamt),
        .last_o   (shift_last),
        .result_o (shift_res)
    );

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        br_d       = br_q;
        ill_d      = ill_q;
        load_shift = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_DONE;
                    br_d    = cond;
                    ill_d   = ill;
                    if (is_shift(Operation)) begin
`ifdef ALU_BARREL_SHIFT_EN
                        res_d = shift_res;
`else
                        if (shamt != '0) begin
                            load_shift = 1'b1;
                            state_d    = ST_SHIFT;
                        end else begin
                            res_d = SrcA;
                        end
`endif
                    end else begin
                        res_d = alu_res;
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_last) begin
                    res_d   = shift_res;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            br_q    <= br_d;
            ill_q   <= ill_d;
        end
    end

    assign out_valid   = (state_q == ST_DONE);
    assign ALUResult   = res_q;
    assign BranchTaken = br_q;
    assign Illegal     = ill_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed and randomized checks of iterative_alu against an arithmetic reference model.
module tb_iterative_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   Operation = 4'd0;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         in_ready, out_valid, BranchTaken, Illegal;
    logic [W-1:0] ALUResult;
    alu_state_e   dbg_state;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    iterative_alu #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Operation   (Operation),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALUResult   (ALUResult),
        .BranchTaken (BranchTaken),
        .Illegal     (Illegal),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: result, branch flag, illegal flag and accept-to-valid latency.
    task automatic ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] res, output logic br, output logic ill,
                           output int lat);
        int sh;
        sh  = int'(b % W);
        res = '0;
        br  = 1'b0;
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0:  res = a & b;
            4'd1:  res = a | b;
            4'd2:  res = a + b;
            4'd4:  res = W'($signed(a) < $signed(b));
            4'd5:  res = a ^ b;
            4'd6:  res = a - b;
            4'd8:  br = (a == b);
            4'd9:  br = (a != b);
            4'd10: br = ($signed(a) < $signed(b));
            4'd11: br = ($signed(a) >= $signed(b));
            4'd13: res = a << sh;
            4'd14: res = a >> sh;
            4'd15: res = W'($signed(a) >>> sh);
            default: ill = 1'b1;
        endcase
        if (op[3:2] == 2'b10) res = W'(br);
`ifndef ALU_BARREL_SHIFT_EN
        if (op >= 4'd13) lat = sh + 1;
`endif
    endtask

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag);
        logic [W-1:0] eres;
        logic ebr, eill;
        int elat, lat;
        ref_alu(op, a, b, eres, ebr, eill, elat);
        exp_q.push_back(eres);
        @(negedge clk);
        check({tag, "/in_ready"}, W'(in_ready), W'(1));
        in_valid  = 1'b1;
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "/out_valid"}, W'(out_valid), W'(1));
        check({tag, "/latency"}, W'(lat), W'(elat));
        check({tag, "/result"}, ALUResult, exp_q.pop_front());
        check({tag, "/branch"}, W'(BranchTaken), W'(ebr));
        check({tag, "/illegal"}, W'(Illegal), W'(eill));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] held;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst/in_ready", W'(in_ready), W'(1));
        check("rst/out_valid", W'(out_valid), W'(0));
        check("rst/result", ALUResult, '0);
        check("rst/branch", W'(BranchTaken), W'(0));
        check("rst/illegal", W'(Illegal), W'(0));
        check("rst/state", W'(dbg_state), W'(ST_IDLE));
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, "add_wrap");
        run_op(4'b0110, 32'd5, 32'd7, "sub_neg");
        run_op(4'b0100, 32'h8000_0000, 32'd1, "slt_signed");
        run_op(4'b1010, 32'h8000_0000, 32'd1, "blt_signed");
        run_op(4'b1011, 32'd3, 32'd3, "bge_eq");
        run_op(4'b1001, 32'd3, 32'd3, "bne_eq");
        run_op(4'b1000, 32'd3, 32'd3, "beq_eq");
        run_op(4'b1111, 32'h8000_0000, 32'd31, "sra_31");
        run_op(4'b1101, 32'd1, 32'h20, "sll_shamt0");
        run_op(4'b1110, 32'hF000_000F, 32'd4, "srl_4");
        run_op(4'b0011, 32'h1234_5678, 32'h9ABC_DEF0, "illegal_0011");
        run_op(4'b1100, 32'h1, 32'h1, "illegal_1100");

        // Backpressure: result must hold, new requests ignored
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; Operation = 4'b0101; SrcA = 32'hA5A5_0F0F; SrcB = 32'h0FF0_FFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        held = 32'hA5A5_0F0F ^ 32'h0FF0_FFFF;
        check("bp/first_valid", W'(out_valid), W'(1));
        @(negedge clk);
        in_valid = 1'b1; Operation = 4'b0010; SrcA = 32'd100; SrcB = 32'd200;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp/valid%0d", i), W'(out_valid), W'(1));
            check($sformatf("bp/in_ready%0d", i), W'(in_ready), W'(0));
            check($sformatf("bp/result%0d", i), ALUResult, held);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp/release_valid", W'(out_valid), W'(0));
        check("bp/release_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        check("bp/no_ghost", W'(out_valid), W'(0));

        // Reset in the middle of a long SRA
        @(negedge clk);
        in_valid = 1'b1; Operation = 4'b1111; SrcA = 32'h8000_0000; SrcB = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
`ifndef ALU_BARREL_SHIFT_EN
        check("midrst/in_shift", W'(dbg_state), W'(ST_SHIFT));
`endif
        reset = 1'b0;
        #1;
        check("midrst/out_valid", W'(out_valid), W'(0));
        check("midrst/in_ready", W'(in_ready), W'(1));
        check("midrst/result", ALUResult, '0);
        check("midrst/state", W'(dbg_state), W'(ST_IDLE));
        @(negedge clk);
        reset = 1'b1;
        run_op(4'b1111, 32'h8000_0000, 32'd20, "post_rst_sra");

        // Randomized operations, including unused codes and shifts
        for (int n = 0; n < 40; n++) begin
            logic [3:0] op;
            logic [W-1:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op(op, a, b, $sformatf("rand%0d_op%0d", n, op));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
